freq_meter: RTL



---
 rtl/freq_meter_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 40 ++++
 rtl/freq_meter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and defaults for the frequency/period meter
package freq_meter_pkg;

    // Measurement sequencer states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        MEAS_HIGH = 3'd2,
        MEAS_LOW  = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Result and counter width
    localparam int DEF_WIDTH = 32;

    // Cycles allowed for the next required edge: 2 s at 50 MHz
    localparam int unsigned DEF_TIMEOUT = 32'd100_000_000;

    // Synchronizer depth for the asynchronous measured input
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchronizer with rise/fall pulse outputs
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    // Shift register: bit 0 faces the asynchronous pin, MSB is the clean level
    logic [SYNC_STAGES-1:0] sync_q;
    // One-cycle delayed copy of the clean level for edge detection
    logic                   s_d;
    logic                   s;

    // Elaboration guard: fewer than two stages gives no metastability margin
    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("sync_edge_det: SYNC_STAGES must be at least 2");
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Synchronizer chain and delay flop, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            s_d    <= s;
        end
    end

    // Both edges see the same pipeline depth, so intervals between them are exact
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - measures period and high time of an async signal in clk cycles
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int          WIDTH       = DEF_WIDTH,
    parameter int          SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter bit          CONTINUOUS  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    // The abort compare value must be reachable by the saturating counter
    if ((64'(TIMEOUT) >> WIDTH) != 64'd0) begin : g_bad_timeout
        $error("freq_meter: TIMEOUT must be less than 2**WIDTH");
    end
    if (TIMEOUT == 0) begin : g_zero_timeout
        $error("freq_meter: TIMEOUT must be at least 1");
    end

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);

    // Edge pulses from the conditioned input
    logic rise;
    logic fall;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .rise (rise),
        .fall (fall)
    );

    // Registered state
    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] hold_high_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] high_time_q;
    logic             valid_q;
    logic             timeout_q;
    logic             busy_q;

    // Next-state values
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] hold_high_nxt;
    logic [WIDTH-1:0] period_nxt;
    logic [WIDTH-1:0] high_time_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;

    // Counter helpers: saturating increment and the abort compare
    logic [WIDTH-1:0] cnt_inc;
    logic             at_limit;

    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    assign at_limit = (cnt_q == CNT_LAST);

    // Next-state and datapath decisions; an edge always beats a timeout
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_inc;
        hold_high_nxt = hold_high_q;
        period_nxt    = period_q;
        high_time_nxt = high_time_q;
        valid_nxt     = 1'b0;
        timeout_nxt   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_nxt = cnt_q;
                if (start) begin
                    state_nxt = ARM;
                    cnt_nxt   = '0;
                end
            end

            ARM: begin
                if (rise) begin
                    // Counting from 1 here makes cnt equal cycles since this rise
                    cnt_nxt   = CNT_ONE;
                    state_nxt = MEAS_HIGH;
                end else if (at_limit) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end

            MEAS_HIGH: begin
                if (fall) begin
                    hold_high_nxt = cnt_q;
                    state_nxt     = MEAS_LOW;
                end else if (at_limit) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end

            MEAS_LOW: begin
                if (rise) begin
                    period_nxt    = cnt_q;
                    high_time_nxt = hold_high_q;
                    valid_nxt     = 1'b1;
                    state_nxt     = DONE;
                    // In free-running mode this rise opens the next measurement
                    if (CONTINUOUS) begin
                        cnt_nxt = CNT_ONE;
                    end
                end else if (at_limit) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end

            DONE: begin
                if (CONTINUOUS) begin
                    // A one-cycle high phase ends while we sit here; catch it
                    if (fall) begin
                        hold_high_nxt = cnt_q;
                        state_nxt     = MEAS_LOW;
                    end else begin
                        state_nxt = MEAS_HIGH;
                    end
                end else begin
                    cnt_nxt   = cnt_q;
                    state_nxt = IDLE;
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset discards any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_high_q <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            hold_high_q <= hold_high_nxt;
            period_q    <= period_nxt;
            high_time_q <= high_time_nxt;
            valid_q     <= valid_nxt;
            timeout_q   <= timeout_nxt;
            busy_q      <= (state_nxt != IDLE);
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule
